// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if: groups the serial line, the consumer acknowledge and the
// receive-side status/data outputs of uart_rx_frontend into one bundle.
//   slave  : the receiver (uart_rx_frontend) - samples UART_RX/RX_READ, drives results
//   master : the environment - drives the line and the acknowledge, observes results
// Signals:
//   UART_RX    serial line, idle high, asynchronous to sysclk
//   RX_READ    consumer acknowledge, level, sampled every sysclk
//   UART_RXD   last received byte
//   RX_EFF     received byte valid, awaiting read
//   FRAME_ERR  one-cycle pulse, stop bit sampled low
//   OVERRUN    sticky, a byte completed while RX_EFF was already set
//   PARITY_ERR one-cycle pulse, even-parity mismatch (only with UART_RX_PARITY_EN)
// Optional feature macro: UART_RX_PARITY_EN.
interface uart_rx_frontend_if;
   logic       UART_RX;
   logic       RX_READ;
   logic [7:0] UART_RXD;
   logic       RX_EFF;
   logic       FRAME_ERR;
   logic       OVERRUN;
`ifdef UART_RX_PARITY_EN
   logic       PARITY_ERR;

   modport slave (
      input  UART_RX,
      input  RX_READ,
      output UART_RXD,
      output RX_EFF,
      output FRAME_ERR,
      output OVERRUN,
      output PARITY_ERR
   );

   modport master (
      output UART_RX,
      output RX_READ,
      input  UART_RXD,
      input  RX_EFF,
      input  FRAME_ERR,
      input  OVERRUN,
      input  PARITY_ERR
   );
`else
   modport slave (
      input  UART_RX,
      input  RX_READ,
      output UART_RXD,
      output RX_EFF,
      output FRAME_ERR,
      output OVERRUN
   );

   modport master (
      output UART_RX,
      output RX_READ,
      input  UART_RXD,
      input  RX_EFF,
      input  FRAME_ERR,
      input  OVERRUN
   );
`endif
endinterface

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampling UART receiver feeding the receive-data register.
// Each bit is decided by a 2-of-3 majority of the samples taken on oversample ticks
// 7, 8 and 9; a start bit that does not survive the vote is dropped as a glitch.
// Ports:
//   sysclk  system clock, rising edge
//   reset   asynchronous active-low reset
//   bus     uart_rx_frontend_if.slave (UART_RX, RX_READ in; UART_RXD, RX_EFF,
//           FRAME_ERR, OVERRUN and optionally PARITY_ERR out)
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), DIV = sysclk cycles per oversample tick (>= 2).
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_frontend #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
   input logic               sysclk,
   input logic               reset,
   uart_rx_frontend_if.slave bus
);

   localparam int unsigned DivW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   // Two-flop synchronizer; both stages reset to the idle line level.
   logic            rx_meta_q, rx_meta_d;
   logic            rx_s_q, rx_s_d;

   state_e          state_q, state_d;
   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic [3:0]      os_cnt_q, os_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [1:0]      samp_q, samp_d;      // captures from os_cnt 7 and 8
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rxd_q, rxd_d;
   logic            eff_q, eff_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
   logic            par_q, par_d;
   logic            perr_q, perr_d;
`endif

   logic tick;
   logic eval;
   logic maj;
   logic par_ok;

   assign tick = (div_cnt_q == DivLast);
   // The third sample is the live synchronized value on the os_cnt=9 tick.
   assign eval = tick && (os_cnt_q == 4'd9);
   assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

`ifdef UART_RX_PARITY_EN
   assign par_ok = ~^{shift_q, par_q};
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      rx_meta_d = bus.UART_RX;
      rx_s_d    = rx_meta_q;
      state_d   = state_q;
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      os_cnt_d  = tick ? os_cnt_q + 4'd1 : os_cnt_q;
      bit_cnt_d = bit_cnt_q;
      samp_d    = samp_q;
      shift_d   = shift_q;
      rxd_d     = rxd_q;
      eff_d     = eff_q;
      ferr_d    = 1'b0;
      ovr_d     = ovr_q;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
      perr_d    = 1'b0;
`endif

      if (tick && (os_cnt_q == 4'd7)) begin
         samp_d[0] = rx_s_q;
      end
      if (tick && (os_cnt_q == 4'd8)) begin
         samp_d[1] = rx_s_q;
      end

      // A read clears the flags; a completion in the same cycle re-raises RX_EFF below.
      if (bus.RX_READ) begin
         eff_d = 1'b0;
         ovr_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            os_cnt_d = 4'd0;
            if (!rx_s_q) begin
               state_d   = StStart;
               // Restart the divider so the ticks line up with the start edge.
               div_cnt_d = '0;
            end
         end

         StStart: begin
            if (eval) begin
               if (!maj) begin
                  state_d   = StData;
                  bit_cnt_d = 3'd0;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         StData: begin
            if (eval) begin
               shift_d = {maj, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (eval) begin
               par_d   = maj;
               state_d = StStop;
            end
         end
`endif

         StStop: begin
            // Leaving at the os_cnt=9 tick leaves margin before a back-to-back start bit.
            if (eval) begin
               state_d = StIdle;
               if (maj && par_ok) begin
                  rxd_d = shift_q;
                  eff_d = 1'b1;
                  if (eff_q && !bus.RX_READ) begin
                     ovr_d = 1'b1;
                  end
               end
               if (!maj) begin
                  ferr_d = 1'b1;
               end
`ifdef UART_RX_PARITY_EN
               if (!par_ok) begin
                  perr_d = 1'b1;
               end
`endif
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= StIdle;
         div_cnt_q <= '0;
         os_cnt_q  <= 4'd0;
         bit_cnt_q <= 3'd0;
         samp_q    <= 2'b00;
         shift_q   <= 8'h00;
         rxd_q     <= 8'h00;
         eff_q     <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         os_cnt_q  <= os_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         samp_q    <= samp_d;
         shift_q   <= shift_d;
         rxd_q     <= rxd_d;
         eff_q     <= eff_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
         par_q     <= par_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign bus.UART_RXD  = rxd_q;
   assign bus.RX_EFF    = eff_q;
   assign bus.FRAME_ERR = ferr_q;
   assign bus.OVERRUN   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: drives serial frames into uart_rx_frontend and compares every
// cycle against a frame-level model (byte register, valid flag, sticky overrun, error
// pulse counts). Completion time is only known to within a few cycles of the stop-bit
// centre, so the model is updated once a window around that point has passed and the
// error pulses seen inside the window are counted instead of timed.
module tb_uart_rx_frontend;

   localparam int unsigned ClkFreq = 1600000;
   localparam int unsigned Baud    = 10000;
   localparam int BitCyc = 160;
`ifdef UART_RX_PARITY_EN
   localparam int NBits = 11;
`else
   localparam int NBits = 10;
`endif
   // Stop-bit centre plus synchronizer and majority-sample delay.
   localparam int Lat = (NBits - 1) * BitCyc + 96;
   localparam int Win = 16;

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      bit         par_ok;
      int         due;
   } frame_t;

   logic   sysclk;
   logic   reset;
   int     cyc;
   int     n_tests;
   int     n_fail;

   logic [7:0] m_rxd;
   logic       m_eff;
   logic       m_ovr;
   frame_t     pend[$];
   frame_t     cur;
   int         fe_cnt;
   int         pe_cnt;
   logic       fe_prev;

   uart_rx_frontend_if bus ();

   uart_rx_frontend #(
      .CLK_FREQ(ClkFreq),
      .BAUD    (Baud)
   ) dut (
      .sysclk(sysclk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   initial cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   initial begin
      #(99000 * 10);
      $display("FAIL watchdog: run still going at cycle %0d, required to finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_rxd = 8'h00;
      m_eff = 1'b0;
      m_ovr = 1'b0;
      pend.delete();
      fe_cnt = 0;
      pe_cnt = 0;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge sysclk) begin
      if (pend.size() > 0 && cyc >= pend[0].due + Win) begin
         cur = pend.pop_front();
         chk("frame_err_pulses", fe_cnt, cur.stop_ok ? 0 : 1);
`ifdef UART_RX_PARITY_EN
         chk("parity_err_pulses", pe_cnt, cur.par_ok ? 0 : 1);
`endif
         if (cur.stop_ok && cur.par_ok) begin
            if (m_eff) m_ovr = 1'b1;
            m_rxd = cur.data;
            m_eff = 1'b1;
         end
         fe_cnt = 0;
         pe_cnt = 0;
      end
      if (pend.size() > 0 && cyc >= pend[0].due - Win) begin
         if (bus.FRAME_ERR === 1'b1) fe_cnt++;
         if (bus.FRAME_ERR === 1'b1 && fe_prev === 1'b1) chk("frame_err_width", 2, 1);
`ifdef UART_RX_PARITY_EN
         if (bus.PARITY_ERR === 1'b1) pe_cnt++;
`endif
      end else begin
         chk("rxd", bus.UART_RXD, m_rxd);
         chk("rx_eff", bus.RX_EFF, m_eff);
         chk("overrun", bus.OVERRUN, m_ovr);
         chk("frame_err_idle", bus.FRAME_ERR, 0);
`ifdef UART_RX_PARITY_EN
         chk("parity_err_idle", bus.PARITY_ERR, 0);
`endif
      end
      fe_prev = bus.FRAME_ERR;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic do_read();
      bus.RX_READ = 1'b1;
      @(posedge sysclk);
      #1;
      bus.RX_READ = 1'b0;
      m_eff = 1'b0;
      m_ovr = 1'b0;
   endtask

   // spike_bit: frame bit index getting a 10-cycle low spike over its middle sample only.
   // abort_bit: frame bit index at whose centre reset is asserted (-1 = none).
   task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit par_ok,
                             input int spike_bit, input int abort_bit);
      logic [10:0] fb;
      frame_t      f;
      fb      = '1;
      fb[0]   = 1'b0;
      fb[8:1] = data;
`ifdef UART_RX_PARITY_EN
      fb[9]   = (^data) ^ !par_ok;
      fb[10]  = stop_ok;
`else
      fb[9]   = stop_ok;
`endif
      f.data    = data;
      f.stop_ok = stop_ok;
      f.par_ok  = par_ok;
      f.due     = cyc + Lat;
      pend.push_back(f);
      for (int b = 0; b < NBits; b++) begin
         for (int k = 0; k < BitCyc; k++) begin
            if (b == abort_bit && k == 80) begin
               reset = 1'b0;
               bus.UART_RX = 1'b1;
               model_reset();
               #1;
               chk("abort_rxd", bus.UART_RXD, 8'h00);
               chk("abort_eff", bus.RX_EFF, 0);
               chk("abort_ovr", bus.OVERRUN, 0);
               idle(20);
               reset = 1'b1;
               idle(20);
               return;
            end
            bus.UART_RX = fb[b];
            if (b == spike_bit && k >= 86 && k < 96) bus.UART_RX = 1'b0;
            @(posedge sysclk);
            #1;
         end
      end
      bus.UART_RX = 1'b1;
   endtask

   initial begin
      logic [7:0] d;
      bit         sok;
      n_tests     = 0;
      n_fail      = 0;
      fe_prev     = 1'b0;
      reset       = 1'b0;
      bus.UART_RX = 1'b1;
      bus.RX_READ = 1'b0;
      model_reset();

      // 1: reset values, then 0xA5.
      idle(5);
      chk("reset_rxd", bus.UART_RXD, 8'h00);
      chk("reset_eff", bus.RX_EFF, 0);
      chk("reset_ovr", bus.OVERRUN, 0);
      chk("reset_ferr", bus.FRAME_ERR, 0);
      reset = 1'b1;
      idle(20);
      send_frame(8'hA5, 1, 1, -1, -1);
      chk("c1_rxd", bus.UART_RXD, 8'hA5);
      chk("c1_eff", bus.RX_EFF, 1);

      // 2: read clears valid, then overrun by two back-to-back bytes.
      do_read();
      chk("c2_read_eff", bus.RX_EFF, 0);
      chk("c2_read_rxd", bus.UART_RXD, 8'hA5);
      send_frame(8'h3C, 1, 1, -1, -1);
      send_frame(8'hC3, 1, 1, -1, -1);
      chk("c2_rxd", bus.UART_RXD, 8'hC3);
      chk("c2_eff", bus.RX_EFF, 1);
      chk("c2_ovr", bus.OVERRUN, 1);
      do_read();
      chk("c2_clr_eff", bus.RX_EFF, 0);
      chk("c2_clr_ovr", bus.OVERRUN, 0);

      // 3: short low glitch on the idle line, then 0x00.
      bus.UART_RX = 1'b0;
      idle(30);
      bus.UART_RX = 1'b1;
      idle(300);
      chk("c3_glitch_eff", bus.RX_EFF, 0);
      send_frame(8'h00, 1, 1, -1, -1);
      chk("c3_rxd", bus.UART_RXD, 8'h00);
      chk("c3_eff", bus.RX_EFF, 1);
      do_read();

      // 4: 0x55 with a low stop bit.
      send_frame(8'h55, 0, 1, -1, -1);
      idle(250);
      chk("c4_rxd", bus.UART_RXD, 8'h00);
      chk("c4_eff", bus.RX_EFF, 0);

      // 5: 0xFF with a single-sample spike in data bit 3.
      send_frame(8'hFF, 1, 1, 4, -1);
      chk("c5_rxd", bus.UART_RXD, 8'hFF);
      do_read();

      // 6: reset during data bit 4 of 0x81, then a clean 0x81.
      send_frame(8'h81, 1, 1, -1, 5);
      idle(50);
      send_frame(8'h81, 1, 1, -1, -1);
      chk("c6_rxd", bus.UART_RXD, 8'h81);
      chk("c6_eff", bus.RX_EFF, 1);
      do_read();
`ifdef UART_RX_PARITY_EN
      send_frame(8'h81, 1, 0, -1, -1);
      idle(50);
      chk("c6_par_eff", bus.RX_EFF, 0);
`endif

      // Randomized frames, gaps, reads and bad stop bits.
      for (int i = 0; i < 28; i++) begin
         d   = 8'($urandom);
         sok = ($urandom_range(0, 6) != 0);
         if ($urandom_range(0, 1) == 1) do_read();
         send_frame(d, sok, 1, -1, -1);
         if (!sok) idle(220 + $urandom_range(0, 50));
         else if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 200));
      end
      idle(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Asynchronous serial receiver that feeds the UART receive-data register inside the data-memory peripheral block.
- Converts the UART_RX pin into bytes on UART_RXD with a valid flag, RX_EFF.
- The CPU-side peripheral clears the flag with RX_READ.
- Uses 16x oversampling, majority-vote bit sampling, glitch rejection on the start bit, and framing/overrun reporting.

Parameters:
CLK_FREQ, 50000000, sysclk frequency in Hz
BAUD, 9600, line rate in bit/s
DIV, CLK_FREQ/(BAUD*16), sysclk cycles per oversample tick (integer truncation; must be >= 2)

Ports:
sysclk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
UART_RX  input  1  serial line, idle high, asynchronous to sysclk
RX_READ  input  1  consumer acknowledge; level, sampled each sysclk
UART_RXD  output  8  last received byte
RX_EFF  output  1  received byte valid, awaiting read
FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low
OVERRUN  output  1  sticky: a byte completed while RX_EFF was already 1

Behaviour:
- Reset is async on reset low. Reset values:
  - UART_RXD=8'h00, RX_EFF=0, FRAME_ERR=0, OVERRUN=0
  - synchronizer flops=1, state=IDLE, all counters 0
- Synchronizer: UART_RX passes through 2 flops; all logic uses the synchronized value rx_s.
- Tick generator:
  - Counter 0..DIV-1, runs free.
  - tick=1 for one sysclk when the counter equals DIV-1.
  - Counter restarts at 0 on the IDLE->START transition so sampling is phase-aligned.
- Oversample counter os_cnt, 0..15: increments on tick, wraps 15->0. Bit counter bit_cnt, 0..7.
- Majority sampling: on ticks with os_cnt=7,8,9, rx_s is captured. Bit value = majority of the 3 captures, evaluated at os_cnt=9.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s=0 -> START, os_cnt=0.
  - START: at os_cnt=9 evaluation:
    - majority 0 -> DATA, bit_cnt=0
    - majority 1 -> IDLE (glitch rejected, no output change)
  - DATA: at os_cnt=9 evaluation, shift the bit in LSB-first (shift reg bit7 <= bit; shift right).
    - bit_cnt=7 -> STOP
    - otherwise bit_cnt+1
  - STOP: at os_cnt=9 evaluation, then -> IDLE in all cases. This leaves ~6 ticks of margin so back-to-back frames are received.
    - majority 1: UART_RXD <= shift reg on the next sysclk.
    - RX_EFF <= 1 on the next sysclk.
    - If RX_EFF was already 1 and RX_READ=0 that cycle, OVERRUN <= 1.
    - majority 0: FRAME_ERR=1 for exactly one sysclk. UART_RXD and RX_EFF are unchanged; the byte is discarded.
- Latency: UART_RXD/RX_EFF update 1 sysclk after the os_cnt=9 tick of the stop bit (~9.5 bit times after the start edge).
- RX_READ=1 in a cycle with no completion: RX_EFF <= 0 and OVERRUN <= 0 next cycle. UART_RXD holds.
- RX_READ=1 in the same cycle as a completion: new byte loaded, RX_EFF stays 1, OVERRUN <= 0.
- Overrun policy: the new byte overwrites UART_RXD (newest wins).
- Line held low (break): START -> DATA -> STOP gives FRAME_ERR. FSM returns to IDLE and re-enters START immediately because rx_s=0. The repeated FRAME_ERR pulses, one per frame time, are accepted behaviour.
- Reset asserted mid-frame: immediate return to reset values. The partial byte is lost and RX_EFF is not raised.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled the same way.
  - Even parity over the 8 data bits plus the parity bit must be 0.
  - Mismatch: output PARITY_ERR (1-bit) pulses one sysclk at the STOP evaluation, and the byte is discarded exactly as for a framing error.
  - Frame is 11 bits.
- Undefined: no PARITY state, no PARITY_ERR port, 10-bit frame.

Test Plan (bench uses CLK_FREQ=1600000, BAUD=10000 -> DIV=10, bit=160 sysclk):
1. Reset low 5 cycles, release, send 8'hA5 (8N1) -> RX_EFF=0 until ~1520 cycles after start edge; then UART_RXD=8'hA5, RX_EFF=1, FRAME_ERR never 1.
2. Hold RX_READ=1 one cycle after case 1 -> RX_EFF=0 next cycle, UART_RXD stays 8'hA5; send 8'h3C then 8'hC3 back-to-back with no read -> UART_RXD=8'hC3, RX_EFF=1, OVERRUN=1; RX_READ pulse clears both.
3. 30-sysclk low glitch on idle UART_RX -> no RX_EFF, no FRAME_ERR, FSM back in IDLE; a subsequent 8'h00 frame is received correctly.
4. Send 8'h55 with stop bit driven low -> FRAME_ERR single-cycle pulse, RX_EFF stays 0, UART_RXD unchanged.
5. Single-tick low spike (10 sysclk) in the middle of data bit 3 of 8'hFF -> majority vote yields 8'hFF.
6. Assert reset mid-way through data bit 4 of 8'h81 -> outputs return to reset values immediately; after release a new 8'h81 frame yields UART_RXD=8'h81. With UART_RX_PARITY_EN, 8'h81 with parity bit 1 -> PARITY_ERR pulse, RX_EFF=0.
